// File: rtl/cpu_types_pkg.sv
// Shared types for the ID/EX pipeline latch: control bundle, bubble constant,
// and the single-action-per-cycle priority decode.
package cpu_types_pkg;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_to_reg;
    logic       mem_wr;
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic       beq;
    logic       bne;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       halt;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    IDEX_HOLD,
    IDEX_LOAD,
    IDEX_BUBBLE,
    IDEX_BUBBLE_BR
  } idex_act_e;

  // mem_wait outranks everything so a flush raised during a memory stall is
  // only honoured once the memory op completes.
  function automatic idex_act_e idex_action(
    input logic mem_wait,
    input logic flush_br,
    input logic flush,
    input logic stall,
    input logic ihit,
    input logic halt_seen
  );
    idex_act_e act;
    act = IDEX_HOLD;
    if (mem_wait)                 act = IDEX_HOLD;
    else if (flush_br)            act = IDEX_BUBBLE_BR;
    else if (flush)               act = ihit ? IDEX_BUBBLE : IDEX_HOLD;
    else if (stall)               act = IDEX_HOLD;
    else if (ihit && !halt_seen)  act = IDEX_LOAD;
    idex_action = act;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; 1-cycle update, no backpressure.
// clr beats inc; the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != {WIDTH{1'b1}}))
      cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline latch with hazard stall/flush, sticky halt and optional
// bubble counters (IDEX_PERF_EN); 1-cycle latency, holds under mem_wait/stall.
module idex_pipe_reg
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        mem_wait,
  input  logic        stall_idex,
  input  logic        flush_idex,
  input  logic        flush_branch_idex,
  input  logic [31:0] instr_in,
  input  logic [31:0] npc_in,
  input  logic [31:0] rdat1_in,
  input  logic [31:0] rdat2_in,
  input  logic [31:0] imm_in,
  input  idex_ctrl_t  ctrl_in,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic [31:0] rdat1_out,
  output logic [31:0] rdat2_out,
  output logic [31:0] imm_out,
  output idex_ctrl_t  ctrl_out,
  output logic        valid_out,
  output logic        halt_seen,
  output logic [31:0] bubble_cnt,
  output logic [31:0] brflush_cnt
);

  idex_act_e act;

  always_comb begin
    act = idex_action(mem_wait, flush_branch_idex, flush_idex, stall_idex,
                      ihit, halt_seen);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_out <= '0;
      npc_out   <= '0;
      rdat1_out <= '0;
      rdat2_out <= '0;
      imm_out   <= '0;
      ctrl_out  <= IDEX_CTRL_BUBBLE;
      valid_out <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      case (act)
        IDEX_LOAD: begin
          instr_out <= instr_in;
          npc_out   <= npc_in;
          rdat1_out <= rdat1_in;
          rdat2_out <= rdat2_in;
          imm_out   <= imm_in;
          ctrl_out  <= ctrl_in;
          valid_out <= 1'b1;
          halt_seen <= ctrl_in.halt;
        end
        // A bubble leaves halt_seen alone: once halted, only reset releases it.
        IDEX_BUBBLE, IDEX_BUBBLE_BR: begin
          instr_out <= '0;
          npc_out   <= '0;
          rdat1_out <= '0;
          rdat2_out <= '0;
          imm_out   <= '0;
          ctrl_out  <= IDEX_CTRL_BUBBLE;
          valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef IDEX_PERF_EN
  sat_counter #(.WIDTH(32)) u_bubble_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (act == IDEX_BUBBLE),
    .cnt (bubble_cnt)
  );

  sat_counter #(.WIDTH(32)) u_brflush_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (act == IDEX_BUBBLE_BR),
    .cnt (brflush_cnt)
  );
`else
  assign bubble_cnt  = '0;
  assign brflush_cnt = '0;
`endif

endmodule

// File: doc/idex_pipe_reg.md
IDEX_PIPE_REG -- requirements
Module: idex_pipe_reg

Interface
REQ-001 SHALL have port CLK, input, 1, single rising-edge clock.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-003 SHALL have port ihit, input, 1, instruction fetch complete; the pipeline may advance.
REQ-004 SHALL have port mem_wait, input, 1, EX/MEM memory op pending without dhit; freezes the latch.
REQ-005 SHALL have ports stall_idex, flush_idex and flush_branch_idex, input, 1 each, hazard-unit commands.
REQ-006 SHALL have ports instr_in and npc_in (32 each), and rdat1_in, rdat2_in and imm_in (32 each), all inputs carrying ID-stage data.
REQ-007 SHALL have port ctrl_in, input, idex_ctrl_t, carrying RegWr, MemtoReg, MemWr, RegDst[1:0], PCSrc[1:0], BEQ, BNE, ALUSrc, ALUOp[3:0] and halt.
REQ-008 SHALL have outputs instr_out, npc_out, rdat1_out, rdat2_out, imm_out and ctrl_out, matching the input widths and holding the registered copies.
REQ-009 SHALL have port valid_out, output, 1, set when the latch holds a real instruction and clear for a bubble.
REQ-010 SHALL have port halt_seen, output, 1, sticky flag set once a halt instruction has been latched.
REQ-011 SHALL have ports bubble_cnt and brflush_cnt, output, 32 each, performance counters (see Configuration).

Function
REQ-012 SHALL update state only on the rising edge of CLK and apply exactly one action per cycle, in this priority order: RST, mem_wait hold, flush_branch_idex, flush_idex, stall_idex hold, load, hold.
REQ-013 mem_wait=1 SHALL hold every register, including the counters, even when a flush input is asserted in the same cycle.
REQ-014 flush_branch_idex=1 SHALL insert a bubble on the next edge regardless of ihit.
REQ-015 flush_idex=1 with ihit=1 SHALL insert a bubble; with ihit=0 it SHALL hold.
REQ-016 A bubble SHALL set all data outputs to 0, ctrl_out to 0 (no RegWr, no MemWr, no halt) and valid_out to 0.
REQ-017 stall_idex=1 with no flush SHALL hold all outputs unchanged.
REQ-018 Load SHALL occur on ihit=1 with no stall, flush or mem_wait, and halt_seen=0; outputs SHALL equal the inputs one cycle later and valid_out SHALL be 1.
REQ-019 halt_seen SHALL set on the edge that loads ctrl_in.halt=1 and SHALL then block all further loads; flushes SHALL still apply.
REQ-020 The latency from input to output SHALL be exactly 1 cycle, with no combinational path from any input to any output.

Reset
REQ-021 RST=1 at an edge SHALL zero every output, including valid_out, halt_seen and both counters, overriding all other inputs.
REQ-022 Reset asserted mid-stall or mid-mem_wait SHALL take effect on that edge, and the first load SHALL occur on the first qualifying edge after RST falls.

Configuration
REQ-023 The macro IDEX_PERF_EN, when defined, SHALL make bubble_cnt increment on each REQ-015 bubble and brflush_cnt increment on each REQ-014 bubble.
REQ-024 Both counters SHALL saturate at 32'hFFFF_FFFF and SHALL NOT wrap.
REQ-025 Without IDEX_PERF_EN, both counters SHALL be tied to 0 and no counter flops SHALL be synthesized.

Structure
REQ-026 idex_ctrl_t SHALL be a packed struct, and the bubble value SHALL be a constant, both defined in cpu_types_pkg.
REQ-027 The counters SHALL be built from one sub-module, sat_counter (32-bit, inc/clr/hold), instantiated twice under IDEX_PERF_EN.

Verification
REQ-028 RST=1 for 2 cycles, then ihit=1 with instr_in=32'h8C220004 -> all outputs 0 during reset; one cycle after release instr_out=32'h8C220004 and valid_out=1.
REQ-029 Hold state A, then stall_idex=1 with ihit=1 and new inputs B for 3 cycles -> outputs stay A for all 3 cycles; B appears 1 cycle after the stall drops.
REQ-030 flush_idex=1 with ihit=0 -> hold; then flush_idex=1 with ihit=1 -> bubble with ctrl_out=0 and valid_out=0, and bubble_cnt=1 when IDEX_PERF_EN is defined.
REQ-031 mem_wait=1 together with flush_branch_idex=1 -> no change; then mem_wait=0 -> bubble and brflush_cnt=1.
REQ-032 Load ctrl_in.halt=1, then 5 further ihit cycles with new instructions -> halt_seen=1 and outputs frozen at the halt instruction; a subsequent flush_branch_idex -> bubble with halt_seen still 1.
REQ-033 Force bubble_cnt to 32'hFFFF_FFFE, then apply 3 flushes -> bubble_cnt stays at 32'hFFFF_FFFF.
